// File: rtl/clken_gen_multi_if.sv
// ----------------------------------------------------------------------------
// clken_gen_multi_if
//   Control and strobe bundle of the clock-enable generator.
//   Signals:
//     div_wr      : one-cycle divider write strobe
//     div_sel     : channel index for div_wr
//     div_val     : new divide ratio
//     sync_req    : one-cycle request to realign all channel counters
//     clken       : rise strobe per channel
//     clken_fall  : mid-period strobe per channel
//     div_pending : channel holds a written ratio not yet applied
//     locked      : generator is in its running state
//   Modports: master drives control and observes strobes; slave is the
//   generator side.
// ----------------------------------------------------------------------------
interface clken_gen_multi_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic              div_wr;
  logic [SEL_W-1:0]  div_sel;
  logic [DIV_W-1:0]  div_val;
  logic              sync_req;
  logic [NUM_CH-1:0] clken;
  logic [NUM_CH-1:0] clken_fall;
  logic [NUM_CH-1:0] div_pending;
  logic              locked;

  modport master (
    output div_wr, div_sel, div_val, sync_req,
    input  clken, clken_fall, div_pending, locked
  );

  modport slave (
    input  div_wr, div_sel, div_val, sync_req,
    output clken, clken_fall, div_pending, locked
  );
endinterface

// File: rtl/clken_gen_multi.sv
// ----------------------------------------------------------------------------
// clken_gen_multi
//   Derives NUM_CH single-cycle clock-enable strobes (rise and mid-period
//   fall) from one PLL master clock by run-time programmable integer
//   division. Strobes only run after PLL lock plus a settle period, and all
//   channels start phase-aligned on lock and on a resync request.
//   Ports:
//     refclk     : master clock
//     rst_n      : asynchronous active-low reset
//     pll_locked : PLL lock, asynchronous (synchronised here)
//     bus        : clken_gen_multi_if.slave (divider writes, sync_req,
//                  clken, clken_fall, div_pending, locked)
// ----------------------------------------------------------------------------
module clken_gen_multi #(
  parameter int                        NUM_CH      = 4,
  parameter int                        DIV_W       = 8,
  parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT    = {8'd32, 8'd8, 8'd4, 8'd1},
  parameter int                        LOCK_CYCLES = 16
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                pll_locked,
  clken_gen_multi_if.slave    bus
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_PLL = 2'd0,
    SETTLE   = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t            state_r;
  logic [SET_W-1:0]  settle_r;
  logic              pll_meta_r;
  logic              pll_s_r;

  logic              run_s;
  logic              stay_run_s;
  logic              sync_s;

  logic [NUM_CH-1:0] clken_s;
  logic [NUM_CH-1:0] clken_fall_s;
  logic [NUM_CH-1:0] pending_s;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_meta_r <= 1'b0;
      pll_s_r    <= 1'b0;
    end else begin
      pll_meta_r <= pll_locked;
      pll_s_r    <= pll_meta_r;
    end
  end

  // Lock sequencing FSM: wait for lock, settle, then run until lock is lost.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= WAIT_PLL;
      settle_r <= '0;
    end else begin
      case (state_r)
        WAIT_PLL: begin
          if (pll_s_r) begin
            state_r  <= SETTLE;
            settle_r <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (!pll_s_r) begin
            state_r <= WAIT_PLL;
          end else if (settle_r == '0) begin
            state_r <= RUN;
          end else begin
            settle_r <= settle_r - SET_W'(1);
          end
        end
        RUN: begin
          if (!pll_s_r) begin
            state_r <= WAIT_PLL;
          end
        end
        default: begin
          state_r  <= WAIT_PLL;
          settle_r <= '0;
        end
      endcase
    end
  end

  // Run qualifiers shared by every channel.
  always_comb begin
    run_s      = (state_r == RUN);
    // Counters only advance while RUN will still hold after this edge.
    stay_run_s = run_s && pll_s_r;
    sync_s     = run_s && bus.sync_req;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] pend_r;
    logic             pending_r;

    logic [DIV_W-1:0] ratio_s;
    logic [DIV_W-1:0] last_s;
    logic             at_last_s;
    logic             wr_hit_s;
    logic             apply_s;

    // Effective ratio (0 behaves as 1), wrap point and apply condition.
    always_comb begin
      ratio_s   = (div_r == '0) ? DIV_W'(1) : div_r;
      last_s    = ratio_s - DIV_W'(1);
      at_last_s = (cnt_r == last_s);
      wr_hit_s  = bus.div_wr && (bus.div_sel == SEL_W'(i));
      // Outside RUN a pending ratio lands immediately; in RUN only at the
      // end of the current period so a period is never truncated.
      apply_s   = pending_r && (!run_s || at_last_s);
    end

    // Channel counter, active ratio and pending-write holding register.
    always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r     <= '0;
        div_r     <= DIV_INIT[i*DIV_W +: DIV_W];
        pend_r    <= '0;
        pending_r <= 1'b0;
      end else begin
        if (!stay_run_s || sync_s || at_last_s) begin
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + DIV_W'(1);
        end

        if (sync_s) begin
          // Resync applies everything at once, a same-cycle write included.
          if (wr_hit_s) begin
            div_r  <= bus.div_val;
            pend_r <= bus.div_val;
          end else if (pending_r) begin
            div_r <= pend_r;
          end else begin
            div_r <= div_r;
          end
          pending_r <= 1'b0;
        end else begin
          if (apply_s) begin
            div_r <= pend_r;
          end else begin
            div_r <= div_r;
          end
          // A write on the apply cycle stays pending for the next boundary.
          if (wr_hit_s) begin
            pend_r    <= bus.div_val;
            pending_r <= 1'b1;
          end else if (apply_s) begin
            pending_r <= 1'b0;
          end else begin
            pending_r <= pending_r;
          end
        end
      end
    end

    assign clken_s[i]      = run_s && (cnt_r == '0);
    assign clken_fall_s[i] = run_s && (ratio_s > DIV_W'(1)) && (cnt_r == (ratio_s >> 1));
    assign pending_s[i]    = pending_r;
  end

  // Drive the strobe bundle from registered state.
  always_comb begin
    bus.clken       = clken_s;
    bus.clken_fall  = clken_fall_s;
    bus.div_pending = pending_s;
    bus.locked      = run_s;
  end

endmodule

// File: tb/tb_clken_gen_multi.sv
// ----------------------------------------------------------------------------
// tb_clken_gen_multi
//   Directed self-checking bench for clken_gen_multi (NUM_CH=4, DIV_W=8,
//   default ratios 1/4/8/32, LOCK_CYCLES=16). Strobes are compared every
//   cycle against hand-chosen per-channel ratio/phase-origin pairs.
// ----------------------------------------------------------------------------
module tb_clken_gen_multi;

  logic refclk;
  logic rst_n;
  logic pll_locked;

  int checks;
  int errors;
  int k;
  int n;
  int exp_r [4];
  int exp_b [4];

  clken_gen_multi_if #(.NUM_CH(4), .DIV_W(8)) bus ();

  clken_gen_multi #(
    .NUM_CH(4),
    .DIV_W(8),
    .DIV_INIT({8'd32, 8'd8, 8'd4, 8'd1}),
    .LOCK_CYCLES(16)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .bus(bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected {clken_fall, clken} at cycle kk from per-channel ratio/origin.
  function automatic logic [7:0] exp_strobes(input int kk);
    logic [3:0] c;
    logic [3:0] f;
    c = 4'd0;
    f = 4'd0;
    for (int ch = 0; ch < 4; ch++) begin
      int m;
      m = (kk - exp_b[ch]) % exp_r[ch];
      c[ch] = (m == 0);
      f[ch] = (exp_r[ch] >= 2) && (m == exp_r[ch] / 2);
    end
    return {f, c};
  endfunction

  task automatic next();
    @(negedge refclk);
  endtask

  task automatic cyc();
    chk($sformatf("strobes_k%0d", k), {24'd0, bus.clken_fall, bus.clken}, {24'd0, exp_strobes(k)});
    next();
    k++;
  endtask

  task automatic run_to(input int target);
    while (k < target) cyc();
  endtask

  task automatic set_model(input int r0, input int r1, input int r2, input int r3, input int base);
    exp_r[0] = r0; exp_r[1] = r1; exp_r[2] = r2; exp_r[3] = r3;
    for (int ch = 0; ch < 4; ch++) exp_b[ch] = base;
  endtask

  // Counts cycles until locked, checking strobes stay quiet meanwhile.
  task automatic wait_lock(inout int cnt);
    while (!bus.locked && cnt < 100) begin
      next();
      cnt++;
      if (!bus.locked) chk("quiet_pre_lock", {24'd0, bus.clken_fall, bus.clken}, 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    k = 0;
    rst_n = 1'b0;
    pll_locked = 1'b1;
    bus.div_wr = 1'b0;
    bus.div_sel = 2'd0;
    bus.div_val = 8'd0;
    bus.sync_req = 1'b0;
    set_model(1, 4, 8, 32, 0);

    // Reset state
    repeat (3) next();
    chk("rst_clken", {28'd0, bus.clken}, 32'd0);
    chk("rst_fall", {28'd0, bus.clken_fall}, 32'd0);
    chk("rst_pending", {28'd0, bus.div_pending}, 32'd0);
    chk("rst_locked", {31'd0, bus.locked}, 32'd0);

    // Lock: 2 sync + 1 entry + 16 settle cycles
    rst_n = 1'b1;
    n = 0;
    wait_lock(n);
    chk("lock_latency", n, 32'd19);
    chk("lock_align", {28'd0, bus.clken}, 32'h0000000F);

    // Default ratios 1/4/8/32
    k = 0;
    run_to(34);

    // ch2 -> 5 mid-period (cnt_2=2)
    bus.div_wr = 1'b1; bus.div_sel = 2'd2; bus.div_val = 8'd5;
    cyc();
    bus.div_wr = 1'b0;
    chk("ch2_pend_set", {28'd0, bus.div_pending}, 32'h4);
    run_to(39);
    chk("ch2_pend_hold", {28'd0, bus.div_pending}, 32'h4);
    cyc();
    exp_r[2] = 5; exp_b[2] = 40;
    chk("ch2_pend_clear", {28'd0, bus.div_pending}, 32'h0);
    chk("ch2_first_new", {31'd0, bus.clken[2]}, 32'd1);
    run_to(57);

    // ch1 written 6 then 3 before its boundary: only 3 lands
    bus.div_wr = 1'b1; bus.div_sel = 2'd1; bus.div_val = 8'd6;
    cyc();
    bus.div_val = 8'd3;
    chk("ch1_pend_first", {28'd0, bus.div_pending}, 32'h2);
    cyc();
    bus.div_wr = 1'b0;
    chk("ch1_pend_second", {28'd0, bus.div_pending}, 32'h2);
    cyc();
    exp_r[1] = 3; exp_b[1] = 60;
    chk("ch1_pend_clear", {28'd0, bus.div_pending}, 32'h0);
    run_to(81);

    // sync_req at cnt_3=17 with same-cycle ch3 write of 10
    bus.sync_req = 1'b1;
    bus.div_wr = 1'b1; bus.div_sel = 2'd3; bus.div_val = 8'd10;
    cyc();
    bus.sync_req = 1'b0;
    bus.div_wr = 1'b0;
    set_model(1, 3, 5, 10, 82);
    chk("sync_align", {28'd0, bus.clken}, 32'hF);
    chk("sync_pend_clear", {28'd0, bus.div_pending}, 32'h0);
    run_to(106);

    // One-cycle lock drop
    pll_locked = 1'b0;
    cyc();
    pll_locked = 1'b1;
    cyc();
    chk("drop_sync_delay", {31'd0, bus.locked}, 32'd1);
    cyc();
    chk("drop_locked", {31'd0, bus.locked}, 32'd0);
    chk("drop_quiet", {24'd0, bus.clken_fall, bus.clken}, 32'd0);

    // Write outside RUN applies on the following cycle
    bus.div_wr = 1'b1; bus.div_sel = 2'd0; bus.div_val = 8'd2;
    next();
    bus.div_wr = 1'b0;
    chk("idle_pend", {28'd0, bus.div_pending}, 32'h1);
    next();
    chk("idle_apply", {28'd0, bus.div_pending}, 32'h0);
    n = 2;
    wait_lock(n);
    chk("relock_latency", n, 32'd17);
    chk("relock_align", {28'd0, bus.clken}, 32'hF);
    k = 0;
    set_model(2, 3, 5, 10, 0);
    run_to(25);

    // Pending ch3 write, then asynchronous reset between edges
    bus.div_wr = 1'b1; bus.div_sel = 2'd3; bus.div_val = 8'd9;
    cyc();
    bus.div_wr = 1'b0;
    chk("pre_rst_pend", {28'd0, bus.div_pending}, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clken", {28'd0, bus.clken}, 32'd0);
    chk("async_fall", {28'd0, bus.clken_fall}, 32'd0);
    chk("async_locked", {31'd0, bus.locked}, 32'd0);
    chk("async_pending", {28'd0, bus.div_pending}, 32'd0);
    next();
    rst_n = 1'b1;
    n = 0;
    wait_lock(n);
    chk("rst_relock_latency", n, 32'd19);
    chk("rst_relock_align", {28'd0, bus.clken}, 32'hF);
    k = 0;
    set_model(1, 4, 8, 32, 0);
    run_to(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clken_gen_multi.md
Name: clken_gen_multi

Overview:
- Parametrised successor to the fixed four-output system PLL wrapper.
- Takes the single PLL master clock and derives NUM_CH single-cycle clock-enable strobes (rise and mid-period "fall") by integer division.
- Dividers are reprogrammable at run time.
- Adds lock sequencing: waits for PLL lock, then a settle period. All channels are phase-aligned on lock and on an explicit resync request.
- Lets the core run everything on one clock domain instead of four PLL outputs.

Parameters:
NUM_CH, 4, number of enable channels (1..16)
DIV_W, 8, width of each divide-ratio field
DIV_INIT, {8'd32,8'd8,8'd4,8'd1}, packed NUM_CH*DIV_W reset divide ratios, channel 0 in LSBs
LOCK_CYCLES, 16, refclk cycles in SETTLE before locked asserts (>=1)

Ports:
refclk  in  1  master clock (PLL outclk_0 domain)
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL lock, asynchronous; synchronised internally
div_wr  in  1  one-cycle divider write strobe
div_sel  in  $clog2(NUM_CH) (min 1)  channel index for div_wr
div_val  in  DIV_W  new divide ratio
sync_req  in  1  one-cycle request to realign all channel counters
clken  out  NUM_CH  rise strobe per channel
clken_fall  out  NUM_CH  mid-period strobe per channel
div_pending  out  NUM_CH  channel has a write not yet applied
locked  out  1  high only in RUN

Behaviour:
- Reset (rst_n low, asynchronous)
  - state=WAIT_PLL; sync flops 0; all cnt_i=0; div_i=DIV_INIT field i; pending cleared.
  - clken=0, clken_fall=0, div_pending=0, locked=0.
- pll_locked passes through a 2-flop synchroniser (pll_s). Latency: 2 cycles.
- FSM states:
  - WAIT_PLL: go to SETTLE when pll_s=1; load settle counter with LOCK_CYCLES-1.
  - SETTLE: decrement the settle counter; go to RUN when it reaches 0 and pll_s=1. If pll_s=0, return to WAIT_PLL.
  - RUN: locked=1. If pll_s=0, go to WAIT_PLL in the next cycle: locked drops, counters clear, strobes stop.
- Outside RUN, all cnt_i are held at 0 and all strobes are 0.
- Effective ratio: r_i = div_i, with div_i=0 treated as 1.
- In RUN, cnt_i increments each cycle and wraps from r_i-1 to 0.
- Strobes (combinational from registered state; no glitch requirement beyond that):
  - clken[i] = RUN && cnt_i==0.
  - clken_fall[i] = RUN && r_i>=2 && cnt_i==r_i>>1.
- Alignment: the first RUN cycle has every cnt_i=0, so all clken bits are high together in the cycle locked first reads 1.
- r_i=1: clken[i] is constant 1 in RUN; clken_fall[i]=0.
- Divider writes:
  - div_wr with div_sel<NUM_CH stores div_val into pend_i and sets div_pending[i] the next cycle.
  - div_sel>=NUM_CH is ignored.
  - A second write before apply overwrites pend_i; last write wins.
  - Apply in RUN: at the cycle where cnt_i==r_i-1, pend_i is copied to div_i and div_pending[i] clears. The next period uses the new ratio; the current period is never truncated.
  - Apply outside RUN: the pending value is applied on the cycle after the write.
  - Write on the apply cycle itself: the value becomes pending for the following boundary.
- sync_req, in RUN only (ignored elsewhere):
  - Next cycle all cnt_i=0 and all clken high.
  - All pending values are applied at that moment, including a same-cycle div_wr.
- Counters and ratios are DIV_W bits wide. Wrap compare uses r_i-1 computed in DIV_W bits; no overflow is possible.
- Loss of lock or reset mid-period aborts the period. No partial strobe is emitted.

Test Plan:
- Reset release with pll_locked=1, LOCK_CYCLES=16, default dividers → locked rises 2+16 cycles later (±1 for SETTLE entry). In that cycle clken=4'b1111. Thereafter:
  - clken[0] is high every cycle.
  - clken[1] pulses every 4 cycles, with clken_fall[1] 2 cycles after each rise.
  - clken[2] pulses every 8 cycles; clken[3] every 32 cycles.
- In RUN, write ch2 div_val=5 mid-period → div_pending[2]=1 until the cycle cnt_2=7. The next clken[2] is 8 cycles after the previous one, later pulses are 5 apart, and clken_fall[2] is at offset 2.
- Two writes to ch1 (6, then 3) before its boundary → only ratio 3 is applied; no period of 6 occurs.
- Drop pll_locked for 1 cycle in RUN → after the 2-cycle synchroniser, locked=0 and all strobes are 0. Reacquire → full LOCK_CYCLES settle, then realigned clken=4'b1111.
- sync_req in RUN when cnt_3=17, plus a same-cycle div_wr ch3=10 → next cycle all clken high; clken[3] then repeats every 10 cycles.
- Assert rst_n low mid-RUN, asynchronously between clock edges → outputs go to 0 immediately, and dividers return to DIV_INIT even after writes.
